// File: rtl/wbuffer_fill_ctrl_if.sv
// Bundle of the fill controller's command, memory read and wbuffer strobe signals.
// master = the fill controller, slave = the environment (memories, wbuffer, sequencer).
interface wbuffer_fill_ctrl_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              step;
  logic              sram_rd_req;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_rd_valid;
  logic              sdram_rd_req;
  logic [ADDR_W-1:0] sdram_addr;
  logic              sdram_rd_valid;
  logic              enable_CU;
  logic [2:0]        mode;
  logic              win_valid;
  logic              exhausted;
  logic              done;

  modport master (
    input  start, step, sram_rd_valid, sdram_rd_valid,
    output sram_rd_req, sram_addr, sdram_rd_req, sdram_addr,
    output enable_CU, mode, win_valid, exhausted, done
  );

  modport slave (
    output start, step, sram_rd_valid, sdram_rd_valid,
    input  sram_rd_req, sram_addr, sdram_rd_req, sdram_addr,
    input  enable_CU, mode, win_valid, exhausted, done
  );
endinterface

// File: rtl/wbuffer_fill_ctrl.sv
// Fetches a two-deep window from SRAM (w_1/w_2) and SDRAM (w_3/w_4) and strobes wbuffer
// with the load/shift opcodes as each word returns.
module wbuffer_fill_ctrl #(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] SRAM_BASE  = '0,
  parameter logic [ADDR_W-1:0] SDRAM_BASE = '0,
  parameter int                NUM_WORDS  = 16
) (
  input  logic                 clk,
  input  logic                 nrst,
  wbuffer_fill_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_F3, S_F4, S_READY, S_SH, S_L2, S_L4, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] NUM_W = ADDR_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  state_t            state_q;
  state_t            nextState;
  logic [ADDR_W-1:0] sramCnt_q;
  logic [ADDR_W-1:0] sdramCnt_q;
  logic              sramReq_q;
  logic              sdramReq_q;
  logic              winValid_q;
  logic              done_q;
  logic              isSram;
  logic              isSdram;
  logic [2:0]        opcode;
  logic              sramHs;
  logic              sdramHs;
  logic              exhausted;

  // Which stream each fetch state reads, the opcode it issues and where it goes next.
  always_comb begin
    isSram    = 1'b0;
    isSdram   = 1'b0;
    opcode    = 3'b000;
    nextState = state_q;
    case (state_q)
      S_F1:    begin isSram  = 1'b1; opcode = 3'b001; nextState = S_F2;    end
      S_F2:    begin isSram  = 1'b1; opcode = 3'b010; nextState = S_F3;    end
      S_L2:    begin isSram  = 1'b1; opcode = 3'b010; nextState = S_L4;    end
      S_F3:    begin isSdram = 1'b1; opcode = 3'b011; nextState = S_F4;    end
      S_F4:    begin isSdram = 1'b1; opcode = 3'b100; nextState = S_READY; end
      S_L4:    begin isSdram = 1'b1; opcode = 3'b100; nextState = S_READY; end
      default: ;
    endcase
  end

  // A valid only counts on the selected port while its request is actually up.
  assign sramHs    = isSram  & sramReq_q  & bus.sram_rd_valid;
  assign sdramHs   = isSdram & sdramReq_q & bus.sdram_rd_valid;
  assign exhausted = (sramCnt_q == NUM_W) && (sdramCnt_q == NUM_W);

  assign bus.sram_rd_req  = sramReq_q;
  assign bus.sdram_rd_req = sdramReq_q;
  assign bus.sram_addr    = SRAM_BASE + sramCnt_q;
  assign bus.sdram_addr   = SDRAM_BASE + sdramCnt_q;
  assign bus.enable_CU    = sramHs | sdramHs | (state_q == S_SH);
  assign bus.mode         = (state_q == S_SH) ? 3'b101 :
                            ((sramHs | sdramHs) ? opcode : 3'b000);
  assign bus.win_valid    = winValid_q;
  assign bus.exhausted    = exhausted;
  assign bus.done         = done_q;

  // Requests drop on the capture edge and are re-raised one cycle later by the next
  // fetch state, which gives the mandatory idle cycle between requests.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      sramCnt_q  <= '0;
      sdramCnt_q <= '0;
      sramReq_q  <= 1'b0;
      sdramReq_q <= 1'b0;
      winValid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_F1;
            sramReq_q  <= 1'b1;
            sramCnt_q  <= '0;
            sdramCnt_q <= '0;
          end
        end
        S_F1, S_F2, S_L2: begin
          if (sramHs) begin
            sramReq_q <= 1'b0;
            sramCnt_q <= sramCnt_q + ONE;
            state_q   <= nextState;
          end else begin
            sramReq_q <= 1'b1;
          end
        end
        S_F3, S_F4, S_L4: begin
          if (sdramHs) begin
            sdramReq_q <= 1'b0;
            sdramCnt_q <= sdramCnt_q + ONE;
            state_q    <= nextState;
            winValid_q <= (nextState == S_READY);
          end else begin
            sdramReq_q <= 1'b1;
          end
        end
        S_READY: begin
          if (bus.step) begin
            winValid_q <= 1'b0;
            if (exhausted) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_SH;
            end
          end
        end
        S_SH: state_q <= S_L2;
        S_DONE: begin
          state_q    <= S_IDLE;
          sramCnt_q  <= '0;
          sdramCnt_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbuffer_fill_ctrl.sv
// Randomised bench for wbuffer_fill_ctrl: dutA runs against a strobe-sequence model with
// random memory latency, stray valids and random start/step; dutB covers NUM_WORDS=2.
module tb_wbuffer_fill_ctrl;

  localparam int          AW           = 16;
  localparam logic [15:0] A_SRAM_BASE  = 16'h0010;
  localparam logic [15:0] A_SDRAM_BASE = 16'hFFFE;
  localparam int          A_NUM        = 4;
  localparam int          B_NUM        = 2;

  logic clk = 1'b0;
  logic nrstA;
  logic nrstB;

  always #5 clk = ~clk;

  wbuffer_fill_ctrl_if #(.ADDR_W(AW)) busA ();
  wbuffer_fill_ctrl_if #(.ADDR_W(AW)) busB ();

  wbuffer_fill_ctrl #(
    .ADDR_W(AW), .SRAM_BASE(A_SRAM_BASE), .SDRAM_BASE(A_SDRAM_BASE), .NUM_WORDS(A_NUM)
  ) dutA (
    .clk(clk), .nrst(nrstA), .bus(busA)
  );

  wbuffer_fill_ctrl #(
    .ADDR_W(AW), .SRAM_BASE(16'h0000), .SDRAM_BASE(16'h0000), .NUM_WORDS(B_NUM)
  ) dutB (
    .clk(clk), .nrst(nrstB), .bus(busB)
  );

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Model of dutA: the ordered list of strobes still owed plus the window status.
  typedef struct {
    logic [2:0]  mode;
    logic [15:0] addr;
  } strobe_t;

  strobe_t expQ[$];
  bit      running;
  bit      modelReady;
  bit      doneCycle;
  bit      stepPhase;
  int      cnt;

  bit          sArmed, dArmed;
  int          sWait, dWait;
  logic [15:0] sHeld, dHeld;
  bit          stallNext;

  task automatic pushStrobe(input logic [2:0] m, input logic [15:0] base, input int idx);
    strobe_t s;
    s.mode = m;
    s.addr = base + 16'(idx);
    expQ.push_back(s);
  endtask

  task automatic clearModel();
    expQ.delete();
    running    = 0;
    modelReady = 0;
    doneCycle  = 0;
    stepPhase  = 0;
    cnt        = 0;
    sArmed     = 0;
    dArmed     = 0;
  endtask

  // Entered and left at posedge+1; resets dutA and checks the post-reset outputs.
  task automatic resetA();
    nrstA = 1'b0;
    busA.start = 1'b0;
    busA.step = 1'b0;
    busA.sram_rd_valid = 1'b0;
    busA.sdram_rd_valid = 1'b0;
    @(posedge clk);
    #1;
    nrstA = 1'b1;
    checkOutput("rstSramReq", busA.sram_rd_req, 0);
    checkOutput("rstSdramReq", busA.sdram_rd_req, 0);
    checkOutput("rstEnable", busA.enable_CU, 0);
    checkOutput("rstMode", busA.mode, 0);
    checkOutput("rstWinValid", busA.win_valid, 0);
    checkOutput("rstExhausted", busA.exhausted, 0);
    checkOutput("rstDone", busA.done, 0);
    checkOutput("rstSramAddr", busA.sram_addr, A_SRAM_BASE);
    checkOutput("rstSdramAddr", busA.sdram_addr, A_SDRAM_BASE);
    clearModel();
  endtask

  // One clock of dutA: memory responder, checks against the model, then model update.
  task automatic applyStimulus(input bit doStart, input bit doStep);
    bit hs;
    bit popped;
    bit startOk;

    if (sArmed) begin
      checkOutput("sramReqHeld", busA.sram_rd_req, 1);
      checkOutput("sramAddrHeld", busA.sram_addr, sHeld);
    end
    if (dArmed) begin
      checkOutput("sdramReqHeld", busA.sdram_rd_req, 1);
      checkOutput("sdramAddrHeld", busA.sdram_addr, dHeld);
    end

    busA.sram_rd_valid = 1'b0;
    if (busA.sram_rd_req) begin
      if (!sArmed) begin
        sArmed = 1;
        sWait  = $urandom_range(0, 3);
        sHeld  = busA.sram_addr;
      end
      if (sWait == 0) begin
        busA.sram_rd_valid = 1'b1;
        sArmed = 0;
      end else begin
        sWait--;
      end
    end else begin
      sArmed = 0;
      busA.sram_rd_valid = ($urandom_range(0, 3) == 0);
    end

    busA.sdram_rd_valid = 1'b0;
    if (busA.sdram_rd_req) begin
      if (!dArmed) begin
        dArmed    = 1;
        dWait     = stallNext ? 10 : int'($urandom_range(0, 3));
        stallNext = 0;
        dHeld     = busA.sdram_addr;
      end
      if (dWait == 0) begin
        busA.sdram_rd_valid = 1'b1;
        dArmed = 0;
      end else begin
        dWait--;
      end
    end else begin
      dArmed = 0;
      busA.sdram_rd_valid = ($urandom_range(0, 3) == 0);
    end

    busA.start = doStart;
    busA.step  = doStep;

    @(negedge clk);
    hs = (busA.sram_rd_valid && busA.sram_rd_req) || (busA.sdram_rd_valid && busA.sdram_rd_req);

    checkOutput("winValid", busA.win_valid, modelReady);
    checkOutput("done", busA.done, doneCycle);
    checkOutput("exhausted", busA.exhausted, running && (cnt == A_NUM) && (expQ.size() == 0));

    popped = 0;
    if (busA.enable_CU) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedStrobe", busA.enable_CU, 0);
      end else begin
        checkOutput("strobeMode", busA.mode, expQ[0].mode);
        if (expQ[0].mode == 3'd1 || expQ[0].mode == 3'd2)
          checkOutput("sramAddr", busA.sram_addr, expQ[0].addr);
        else if (expQ[0].mode == 3'd3 || expQ[0].mode == 3'd4)
          checkOutput("sdramAddr", busA.sdram_addr, expQ[0].addr);
        if (expQ[0].mode != 3'd5)
          checkOutput("strobeOnValid", hs, 1);
        void'(expQ.pop_front());
        popped = 1;
      end
    end else begin
      checkOutput("idleMode", busA.mode, 0);
      if (hs)
        checkOutput("missedStrobe", busA.enable_CU, 1);
    end

    startOk = doStart && !running;
    if (doneCycle) begin
      doneCycle = 0;
      running   = 0;
      cnt       = 0;
    end else if (doStep && modelReady) begin
      modelReady = 0;
      if (cnt == A_NUM) begin
        doneCycle = 1;
      end else begin
        pushStrobe(3'd5, 16'h0, 0);
        pushStrobe(3'd2, A_SRAM_BASE, cnt);
        pushStrobe(3'd4, A_SDRAM_BASE, cnt);
        cnt++;
        stepPhase = 1;
      end
    end else if (popped && expQ.size() == 0) begin
      modelReady = 1;
    end
    if (startOk) begin
      running   = 1;
      stepPhase = 0;
      cnt       = 2;
      pushStrobe(3'd1, A_SRAM_BASE, 0);
      pushStrobe(3'd2, A_SRAM_BASE, 1);
      pushStrobe(3'd3, A_SDRAM_BASE, 0);
      pushStrobe(3'd4, A_SDRAM_BASE, 1);
    end

    @(posedge clk);
    #1;
  endtask

  // dutB: memories answer in the same cycle a request is seen; strobes are logged.
  logic [2:0]  bModes[$];
  logic [15:0] bAddrs[$];
  logic        bDone, bEnable, bWinValid, bExhausted;

  task automatic runB(input bit doStart, input bit doStep);
    busB.sram_rd_valid  = busB.sram_rd_req;
    busB.sdram_rd_valid = busB.sdram_rd_req;
    busB.start = doStart;
    busB.step  = doStep;
    @(negedge clk);
    bDone      = busB.done;
    bEnable    = busB.enable_CU;
    bWinValid  = busB.win_valid;
    bExhausted = busB.exhausted;
    if (busB.enable_CU) begin
      bModes.push_back(busB.mode);
      bAddrs.push_back((busB.mode <= 3'd2) ? busB.sram_addr : busB.sdram_addr);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit hit;
    logic [2:0]  bExpMode[4];
    logic [15:0] bExpAddr[4];

    nrstA = 1'b0;
    nrstB = 1'b0;
    busA.start = 1'b0; busA.step = 1'b0;
    busA.sram_rd_valid = 1'b0; busA.sdram_rd_valid = 1'b0;
    busB.start = 1'b0; busB.step = 1'b0;
    busB.sram_rd_valid = 1'b0; busB.sdram_rd_valid = 1'b0;
    stallNext = 0;
    clearModel();
    @(posedge clk);
    #1;
    resetA();

    for (int i = 0; i < 800; i++) begin
      if (i % 150 == 20) stallNext = 1;
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
    end

    // Drive the run into L4 with its SDRAM request up, then reset it there.
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      if (stepPhase && expQ.size() == 1 && busA.sdram_rd_req) begin
        hit = 1;
        resetA();
      end else begin
        applyStimulus(!running, modelReady);
      end
    end
    checkOutput("reachL4", hit, 1);

    applyStimulus(1, 0);
    for (int i = 0; i < 60 && !modelReady; i++) applyStimulus(0, 0);
    checkOutput("refillDone", modelReady, 1);
    for (int i = 0; i < 100; i++)
      applyStimulus(!running, modelReady && $urandom_range(0, 2) == 0);

    // NUM_WORDS=2 instance: fill, then a step goes straight to DONE.
    nrstB = 1'b0;
    @(posedge clk);
    #1;
    nrstB = 1'b1;
    checkOutput("bRstReq", busB.sram_rd_req | busB.sdram_rd_req, 0);
    runB(1, 0);
    for (int i = 0; i < 30 && !bWinValid; i++) runB(0, 0);
    bExpMode = '{3'd1, 3'd2, 3'd3, 3'd4};
    bExpAddr = '{16'd0, 16'd1, 16'd0, 16'd1};
    checkOutput("bStrobeCount", bModes.size(), 4);
    for (int i = 0; i < 4 && i < bModes.size(); i++) begin
      checkOutput("bFillMode", bModes[i], bExpMode[i]);
      checkOutput("bFillAddr", bAddrs[i], bExpAddr[i]);
    end
    checkOutput("bWinValid", bWinValid, 1);
    checkOutput("bExhausted", bExhausted, 1);
    runB(0, 1);
    runB(0, 0);
    checkOutput("bDonePulse", bDone, 1);
    checkOutput("bDoneNoStrobe", bEnable, 0);
    checkOutput("bDoneWinValid", bWinValid, 0);
    runB(0, 0);
    checkOutput("bDoneCleared", bDone, 0);
    checkOutput("bIdleExhausted", bExhausted, 0);
    checkOutput("bNoShift", bModes.size(), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
